imm_encode: RTL and testbench
=============================

# imm_encode

Multi-cycle immediate encoder for the ARM single-cycle processor toolchain and self-test path. It is the inverse of the datapath's immediate extension. Given a 32-bit constant and an `ImmSrc` class, it produces the 24-bit instruction immediate field that the extender expands back to the same constant, or it flags the constant as unencodable. It is used by the on-chip test-program generator and by the instruction-memory loader's checker.

## Interface
Parameters: none.

- `clk`  in  1  clock
- `reset`  in  1  reset; synchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `ImmSrc`  in  2  immediate class: 00 = 8-bit unsigned, 01 = 12-bit unsigned, 10 = 24-bit branch, 11 = invalid
- `Value`  in  32  constant to encode; for class 10, a byte offset
- `busy`  out  1  high from the accept edge until the result edge
- `done`  out  1  single-cycle result pulse
- `ok`  out  1  result is encodable; valid while `done` is high, then held
- `Instr`  out  24  encoded field `Instr[23:0]`; valid while `done` is high, then held

## Operation
- **States:**
  - IDLE
  - CHECK: one cycle, non-search classes.
  - SEARCH: `ROT_IMM_EN` builds only, class 00.
- **IDLE:** when `start`=1, register `ImmSrc`/`Value`, set `busy`=1, and go to CHECK. If the class is 00 and `ROT_IMM_EN` is defined, go to SEARCH instead.
- **CHECK rules:**
  - Class 00: `ok` = (`Value[31:8]`==0); `Instr` = {16'b0, `Value[7:0]`}.
  - Class 01: `ok` = (`Value[31:12]`==0); `Instr` = {12'b0, `Value[11:0]`}.
  - Class 10: `ok` = (`Value[1:0]`==0) && (`Value[31:25]` all equal to `Value[25]`). The accepted range is -2^25 to 2^25-4. `Instr` = `Value[25:2]`.
  - Class 11: `ok`=0; `Instr`=0.
- **Unencodable results:** whenever `ok`=0, `Instr` is forced to 0.
- **SEARCH:**
  - Uses a 4-bit counter `rot` (0..15) and a working register W, which starts at the captured `Value`.
  - Each cycle, test W[31:8]==0.
  - On a hit: `ok`=1, `Instr` = {12'b0, `rot`, W[7:0]}, return to IDLE.
  - On a miss: W = rotate-left(W, 2), `rot`++.
  - A miss at `rot`=15 ends the search with `ok`=0, `Instr`=0.
  - The smallest `rot` always wins. No barrel shifter: W rotates by 2 per cycle.
- **Result edge:** registers `ok`/`Instr`, sets `done`=1 for one cycle, sets `busy`=0, and the state returns to IDLE.
- **Held outputs:** `ok` and `Instr` hold until the next result edge.
- **`start` handling:**
  - `start` is ignored while `busy`=1.
  - `start` is accepted in the cycle where `done`=1, because the state is already IDLE.
- **Reset:**
  - All outputs go to 0 (`busy`, `done`, `ok`, `Instr`=0).
  - State goes to IDLE; `rot` and W are cleared.
  - Reset during CHECK or SEARCH aborts the operation with no `done` pulse.

## Timing
- `start` is sampled at edge E0 and `busy` rises at E0.
- CHECK results register at E1: `done` is high in cycle E1..E2 and `busy` falls at E1. Latency is 1 cycle.
- SEARCH tests `rot`=r during cycle E(r)..E(r+1); a hit at r registers at E(r+1). Latency is r+1 cycles.
- The worst case, no hit, registers at E16.
- Back-to-back operation: `start` high during the `done` cycle is accepted at E1 (CHECK) or E(r+1) (SEARCH).
- If `reset` and `start` are high on the same edge, `reset` wins.

## Configuration
- **`ROT_IMM_EN` defined:**
  - Class 00 uses the ARM rotated-immediate form: `Value` = ROR(imm8, 2·`rot`), encoded as `Instr[11:8]`=`rot`, `Instr[7:0]`=imm8.
  - Class 00 always goes through SEARCH, with latency 1..16 cycles.
- **`ROT_IMM_EN` undefined:**
  - Class 00 is plain 8-bit zero-extension through CHECK, with latency 1 cycle.
  - The SEARCH state, `rot`, and W are not compiled.

## Test plan
- **Class 00, unrotated:** `ImmSrc`=00, `Value`=0x000000AB -> `done` at E1, `ok`=1, `Instr`=0x0000AB. Holds in both builds; with `ROT_IMM_EN` the hit is at `rot`=0.
- **Class 00, rotated hit:** `ROT_IMM_EN` defined, `ImmSrc`=00, `Value`=0xFF000000 -> `done` at E5, `ok`=1, `Instr`=0x0004FF. The same `Value` without the macro -> E1, `ok`=0, `Instr`=0.
- **Class 00, no encoding:** `ROT_IMM_EN` defined, `ImmSrc`=00, `Value`=0x00000101 -> `done` at E16, `ok`=0, `Instr`=0, `busy` high E0..E16.
- **Class 10, branch:**
  - `Value`=0xFFFFFFF8 -> `ok`=1, `Instr`=0xFFFFFE.
  - `Value`=0x01FFFFFC -> `ok`=1, `Instr`=0x7FFFFF.
  - `Value`=0x02000000 -> `ok`=0.
  - `Value`=0x00000006 -> `ok`=0.
  - All results at E1.
- **Class 01 and 11:**
  - Class 01, `Value`=0x00000FFF -> `ok`=1, `Instr`=0x000FFF.
  - Class 01, `Value`=0x00001000 -> `ok`=0, `Instr`=0.
  - Class 11, `Value`=0 -> `ok`=0.
- **Control:**
  - `start` pulsed while `busy` -> ignored; the result matches the first request.
  - `reset` asserted at the 3rd SEARCH cycle -> no `done`; all outputs 0 the next cycle.
  - `start` during the `done` cycle -> accepted, with a second `done` after the expected latency.

Source files
------------

// File: rtl/imm_encode.sv
// imm_encode: multi-cycle inverse of the datapath immediate extender.
// Takes a 32-bit constant plus an ImmSrc class and returns the 24-bit
// instruction immediate field that expands back to that constant. If no
// such field exists, it flags the constant as unencodable.
//
// Optional feature macro: ROT_IMM_EN
//   When defined, class 00 uses the ARM rotated 8-bit immediate form.
//   The encoding is found by a serial search that rotates by 2 bits per cycle.
//   When undefined, class 00 is a plain 8-bit zero-extension.
//
// Ports:
//   clk     in   1   clock
//   reset   in   1   synchronous, active-high reset
//   start   in   1   request, sampled only in IDLE
//   ImmSrc  in   2   00 imm8, 01 imm12, 10 branch offset, 11 invalid
//   Value   in  32   constant to encode (byte offset for class 10)
//   busy    out  1   high from the accept edge until the result edge
//   done    out  1   one-cycle result pulse
//   ok      out  1   result encodable; held until the next result
//   Instr   out 24   encoded field, forced to 0 when not ok; held
module imm_encode (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  ImmSrc,
    input  logic [31:0] Value,
    output logic        busy,
    output logic        done,
    output logic        ok,
    output logic [23:0] Instr
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] SEARCH = 2'd2;

    logic [1:0]  state;
    logic [1:0]  src;
    logic [31:0] val;

    logic        chk_ok;
    logic [23:0] chk_instr;

    // Single-cycle rules for the non-search classes.
    always_comb begin
        chk_ok    = 1'b0;
        chk_instr = 24'd0;
        case (src)
            2'b00: begin
                chk_ok    = (val[31:8] == 24'd0);
                chk_instr = {16'd0, val[7:0]};
            end
            2'b01: begin
                chk_ok    = (val[31:12] == 20'd0);
                chk_instr = {12'd0, val[11:0]};
            end
            2'b10: begin
                // Word aligned and sign bits 31:25 all replicate bit 25.
                chk_ok    = (val[1:0] == 2'b00) &&
                            ((&val[31:25]) || !(|val[31:25]));
                chk_instr = val[25:2];
            end
            default: begin
                chk_ok    = 1'b0;
                chk_instr = 24'd0;
            end
        endcase
        if (!chk_ok) begin
            chk_instr = 24'd0;
        end
    end

`ifdef ROT_IMM_EN
    logic [3:0]  rot;
    logic [31:0] w;
    logic        hit;

    assign hit = (w[31:8] == 24'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            src   <= 2'd0;
            val   <= 32'd0;
            rot   <= 4'd0;
            w     <= 32'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ok    <= 1'b0;
            Instr <= 24'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src  <= ImmSrc;
                        val  <= Value;
                        busy <= 1'b1;
                        if (ImmSrc == 2'b00) begin
                            w     <= Value;
                            rot   <= 4'd0;
                            state <= SEARCH;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    ok    <= chk_ok;
                    Instr <= chk_instr;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                SEARCH: begin
                    if (hit) begin
                        ok    <= 1'b1;
                        Instr <= {12'd0, rot, w[7:0]};
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (rot == 4'd15) begin
                        ok    <= 1'b0;
                        Instr <= 24'd0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        // Rotating W left by 2 undoes one step of ROR by 2*rot.
                        w   <= {w[29:0], w[31:30]};
                        rot <= rot + 4'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            src   <= 2'd0;
            val   <= 32'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ok    <= 1'b0;
            Instr <= 24'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src   <= ImmSrc;
                        val   <= Value;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    ok    <= chk_ok;
                    Instr <= chk_instr;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_imm_encode.sv
// Directed self-checking bench for imm_encode. It runs in both builds;
// expectations that depend on ROT_IMM_EN are selected with the same macro.
module tb_imm_encode;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  ImmSrc;
    logic [31:0] Value;
    logic        busy;
    logic        done;
    logic        ok;
    logic [23:0] Instr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_encode dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .ImmSrc (ImmSrc),
        .Value  (Value),
        .busy   (busy),
        .done   (done),
        .ok     (ok),
        .Instr  (Instr)
    );

    // Issue one request and measure latency in cycles after the accept edge.
    // lat is -1 if no done pulse is seen within the bound.
    task automatic issue(input logic [1:0] src, input logic [31:0] val, output int lat,
                         output logic r_ok, output logic [23:0] r_instr, output int nbusy);
        @(negedge clk);
        ImmSrc = src;
        Value  = val;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = -1;
        r_ok    = 1'b0;
        r_instr = 24'd0;
        nbusy   = (busy === 1'b1) ? 1 : 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat     = i;
                r_ok    = ok;
                r_instr = Instr;
                break;
            end
            if (busy === 1'b1) nbusy++;
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        start  = 1'b0;
        ImmSrc = 2'b00;
        Value  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL reset_ok got %b want 0", ok); end
        checks++; if (Instr !== 24'd0) begin errors++; $display("FAIL reset_instr got %h want 0", Instr); end
    endtask

    task automatic test_class00;
        int lat; int nb; logic rok; logic [23:0] rin;
        issue(2'b00, 32'h0000_00AB, lat, rok, rin, nb);
        checks++; if (lat !== 1) begin errors++; $display("FAIL c00_plain_lat got %0d want 1", lat); end
        checks++; if (rok !== 1'b1) begin errors++; $display("FAIL c00_plain_ok got %b want 1", rok); end
        checks++; if (rin !== 24'h0000AB) begin errors++; $display("FAIL c00_plain_instr got %h want 0000ab", rin); end
`ifdef ROT_IMM_EN
        issue(2'b00, 32'hFF00_0000, lat, rok, rin, nb);
        checks++; if (lat !== 5) begin errors++; $display("FAIL c00_rot_lat got %0d want 5", lat); end
        checks++; if (rok !== 1'b1) begin errors++; $display("FAIL c00_rot_ok got %b want 1", rok); end
        checks++; if (rin !== 24'h0004FF) begin errors++; $display("FAIL c00_rot_instr got %h want 0004ff", rin); end
        checks++; if (nb !== 5) begin errors++; $display("FAIL c00_rot_busy got %0d want 5", nb); end
        issue(2'b00, 32'h0000_0101, lat, rok, rin, nb);
        checks++; if (lat !== 16) begin errors++; $display("FAIL c00_miss_lat got %0d want 16", lat); end
        checks++; if (rok !== 1'b0) begin errors++; $display("FAIL c00_miss_ok got %b want 0", rok); end
        checks++; if (rin !== 24'd0) begin errors++; $display("FAIL c00_miss_instr got %h want 0", rin); end
        checks++; if (nb !== 16) begin errors++; $display("FAIL c00_miss_busy got %0d want 16", nb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL c00_miss_busy_end got %b want 0", busy); end
`else
        issue(2'b00, 32'hFF00_0000, lat, rok, rin, nb);
        checks++; if (lat !== 1) begin errors++; $display("FAIL c00_wide_lat got %0d want 1", lat); end
        checks++; if (rok !== 1'b0) begin errors++; $display("FAIL c00_wide_ok got %b want 0", rok); end
        checks++; if (rin !== 24'd0) begin errors++; $display("FAIL c00_wide_instr got %h want 0", rin); end
        checks++; if (nb !== 1) begin errors++; $display("FAIL c00_wide_busy got %0d want 1", nb); end
`endif
    endtask

    task automatic test_class10;
        logic [31:0] vals [4] = '{32'hFFFF_FFF8, 32'h01FF_FFFC, 32'h0200_0000, 32'h0000_0006};
        logic        oks  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [23:0] ins  [4] = '{24'hFFFFFE, 24'h7FFFFF, 24'h000000, 24'h000000};
        int lat; int nb; logic rok; logic [23:0] rin;
        for (int i = 0; i < 4; i++) begin
            issue(2'b10, vals[i], lat, rok, rin, nb);
            checks++; if (lat !== 1) begin errors++; $display("FAIL c10_lat[%0d] got %0d want 1", i, lat); end
            checks++; if (rok !== oks[i]) begin errors++; $display("FAIL c10_ok[%0d] got %b want %b", i, rok, oks[i]); end
            checks++; if (rin !== ins[i]) begin errors++; $display("FAIL c10_instr[%0d] got %h want %h", i, rin, ins[i]); end
        end
    endtask

    task automatic test_class01_11;
        int lat; int nb; logic rok; logic [23:0] rin;
        issue(2'b01, 32'h0000_0FFF, lat, rok, rin, nb);
        checks++; if (lat !== 1) begin errors++; $display("FAIL c01_max_lat got %0d want 1", lat); end
        checks++; if (rok !== 1'b1) begin errors++; $display("FAIL c01_max_ok got %b want 1", rok); end
        checks++; if (rin !== 24'h000FFF) begin errors++; $display("FAIL c01_max_instr got %h want 000fff", rin); end
        // Held outputs after the pulse.
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done got %b want 0", done); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hold_ok got %b want 1", ok); end
        checks++; if (Instr !== 24'h000FFF) begin errors++; $display("FAIL hold_instr got %h want 000fff", Instr); end
        issue(2'b01, 32'h0000_1000, lat, rok, rin, nb);
        checks++; if (rok !== 1'b0) begin errors++; $display("FAIL c01_over_ok got %b want 0", rok); end
        checks++; if (rin !== 24'd0) begin errors++; $display("FAIL c01_over_instr got %h want 0", rin); end
        issue(2'b01, 32'h0000_0123, lat, rok, rin, nb);
        issue(2'b11, 32'h0000_0000, lat, rok, rin, nb);
        checks++; if (lat !== 1) begin errors++; $display("FAIL c11_lat got %0d want 1", lat); end
        checks++; if (rok !== 1'b0) begin errors++; $display("FAIL c11_ok got %b want 0", rok); end
        checks++; if (rin !== 24'd0) begin errors++; $display("FAIL c11_instr got %h want 0", rin); end
    endtask

    task automatic test_busy_ignore;
        int seen = 0;
        @(negedge clk);
        ImmSrc = 2'b01;
        Value  = 32'h0000_0123;
        start  = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %b want 1", busy); end
        // Hold start with a different request until the result edge.
        ImmSrc = 2'b11;
        Value  = 32'h0000_0456;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1;
        end
        start = 1'b0;
        checks++; if (seen !== 1) begin errors++; $display("FAIL ign_done got %0d want 1", seen); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ign_ok got %b want 1", ok); end
        checks++; if (Instr !== 24'h000123) begin errors++; $display("FAIL ign_instr got %h want 000123", Instr); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ign_extra_done got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_extra_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int lat; int nb; logic rok; logic [23:0] rin;
        issue(2'b01, 32'h0000_00FF, lat, rok, rin, nb);
        checks++; if (rin !== 24'h0000FF) begin errors++; $display("FAIL b2b_first got %h want 0000ff", rin); end
        // Still inside the done cycle: request the next one now.
        ImmSrc = 2'b10;
        Value  = 32'hFFFF_FFF8;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_gap_done got %b want 0", done); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_ok got %b want 1", ok); end
        checks++; if (Instr !== 24'hFFFFFE) begin errors++; $display("FAIL b2b_instr got %h want fffffe", Instr); end
    endtask

    task automatic test_reset_abort;
        int lat; int nb; logic rok; logic [23:0] rin; int seen = 0;
        issue(2'b01, 32'h0000_0FFF, lat, rok, rin, nb);
        @(negedge clk);
`ifdef ROT_IMM_EN
        ImmSrc = 2'b00;
        Value  = 32'h0000_0101;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`else
        ImmSrc = 2'b01;
        Value  = 32'h0000_0001;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL abort_ok got %b want 0", ok); end
        checks++; if (Instr !== 24'd0) begin errors++; $display("FAIL abort_instr got %h want 0", Instr); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_late_done got %0d want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_class00();
        test_class10();
        test_class01_11();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
